playtime_display: RTL
=====================

# playtime_display

Playback-time and track-index tracker for the audio player. Counts elapsed playback time as mm:ss from an internal 1 s prescaler, freezes on pause, clears on track change or track end, and drives the seconds and minutes seven-segment displays. Sits between the player control switches and the HEX outputs of the audio system. It generalises the fixed two-digit minute/second display with a parametrised minute-digit count, segment polarity, track count and automatic end-of-track advance.

## Interface
- CLK_HZ, 50000000: clock cycles per displayed second (≥ 2)
- MIN_DIGITS, 2: number of minute digits, 1..3
- NUM_TRACKS, 8: track index wraps modulo this value (≥ 1)
- SEG_ACTIVE_LOW, 1: 1 = segment on when bit is 0
- DEB_CYCLES, 500000: debounce stable count; used only with the debounce feature (≥ 1)

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous, active-high reset
- pausa_sw  in  1  level; 1 = paused
- siguiente_sw  in  1  next track on rising edge
- anterior_sw  in  1  previous track on rising edge
- track_len_sec  in  12  current track length in seconds; 0 = unlimited
- seg1_export  out  7  seconds units digit
- seg2_export  out  7  seconds tens digit
- min_export  out  7*MIN_DIGITS  minute digits; units in [6:0]
- track_idx  out  $clog2(NUM_TRACKS) (min 1)  current track
- track_end  out  1  one-cycle pulse on auto-advance
- elapsed_sec  out  12  total elapsed seconds (binary)

## Operation
- Inputs pass through a 2-flop synchroniser. Rising-edge detection is applied to siguiente and anterior after synchronisation, or after debouncing when that is enabled.
- Counters: sec_u (0..9), sec_t (0..5), minute BCD digits, and elapsed_sec in binary.
- States:
  - RUN: prescaler counts 0..CLK_HZ-1. On wrap, time advances by 1 s.
  - PAUSED: prescaler and time hold their values.
  - Transitions: RUN↔PAUSED follow the synchronised pausa level.
- Second advance:
  - sec_u 9→0 carries to sec_t.
  - sec_t 5→0 carries to minutes.
  - Minutes carry in BCD.
  - At max (10^MIN_DIGITS−1):59, time saturates and elapsed_sec holds.
- Track end: when track_len_sec≠0 and a second advance would make elapsed_sec == track_len_sec:
  - time clears to 00:00 instead;
  - track_idx increments with wrap;
  - track_end pulses. This works in RUN only.
- Track change:
  - siguiente edge: track_idx+1, wrapping NUM_TRACKS−1→0.
  - anterior edge: track_idx−1, wrapping 0→NUM_TRACKS−1.
  - Either change clears time, elapsed_sec and the prescaler. Pause state is unchanged.
- Simultaneous events in one cycle:
  - siguiente beats anterior.
  - A manual change beats auto-advance; track_end is not pulsed.
  - A change while paused is applied.
- Segment encoding (active-high, bits g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. SEG_ACTIVE_LOW inverts all bits.
- Reset:
  - time 00:00, elapsed_sec 0, track_idx 0, track_end 0, prescaler 0, synchronisers 0.
  - All digit outputs show "0": 7'h40 active-low, 7'h3F active-high.
  - Reset applied mid-count or mid-debounce aborts the operation in progress.

## Timing
- Input to synchronised value: 2 cycles. Edge detect: +1 cycle. The track_idx and counter update lands on that same edge.
- Without debounce: siguiente rise at cycle n → track_idx updated at cycle n+3 edge.
- With debounce: add DEB_CYCLES cycles.
- Pause is effective 2 cycles after pausa_sw changes.
- Digit outputs are registered from the counters: 1-cycle lag after a counter update. track_idx, elapsed_sec and track_end are direct registers.
- In RUN with no events, a second advance occurs every CLK_HZ cycles exactly.

## Configuration
- PLAYTIME_DEBOUNCE_EN defined:
  - each synchronised input feeds a debouncer;
  - output changes only after the input is stable for DEB_CYCLES consecutive cycles;
  - a glitch shorter than DEB_CYCLES is ignored and the counter restarts on every change.
- Not defined: debouncers are omitted, DEB_CYCLES is unused, and synchronised inputs feed edge detection directly.

## Test plan
- CLK_HZ=10, active-low, reset released, run 600 cycles → reaches 01:00. seg1_export=7'h40, seg2_export=7'h40, min units=7'h79, elapsed_sec=60.
- MIN_DIGITS=1, run to 9:59, then +10 cycles → holds 9:59 with elapsed_sec=599.
- pausa_sw=1 at 00:07 with prescaler mid-count, hold 100 cycles, release → stays 00:07 during pause, then resumes from the same prescaler value.
- track_len_sec=5, NUM_TRACKS=4, track_idx=3 → after 50 cycles, track_end pulses for 1 cycle, track_idx=0, time 00:00.
- siguiente_sw and anterior_sw rise in the same cycle from track 2 → track_idx=3 at cycle n+3 and time cleared. Then anterior alone at track 0 → track_idx=3.
- With PLAYTIME_DEBOUNCE_EN and DEB_CYCLES=4:
  - a 3-cycle siguiente pulse leaves track_idx unchanged;
  - a 6-cycle pulse advances it at cycle n+7;
  - reset asserted mid-debounce clears everything.

Source files
------------

// File: rtl/playtime_display_if.sv
// playtime_display_if: player switches and status/HEX outputs of playtime_display.
// Every signal is a plain level or a registered output. There is no valid/ready
// handshake: the DUT samples its inputs on every clock and its outputs are valid
// on every clock. siguiente_sw/anterior_sw act on their rising edge only.
interface playtime_display_if #(
    parameter int MIN_DIGITS = 2,
    parameter int NUM_TRACKS = 8
);
    localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;

    logic                    pausa_sw;
    logic                    siguiente_sw;
    logic                    anterior_sw;
    logic [11:0]             track_len_sec;
    logic [6:0]              seg1_export;
    logic [6:0]              seg2_export;
    logic [7*MIN_DIGITS-1:0] min_export;
    logic [TW-1:0]           track_idx;
    logic                    track_end;
    logic [11:0]             elapsed_sec;
    logic                    dbg_state;     // 0 = RUN, 1 = PAUSED

    modport master (
        output pausa_sw, siguiente_sw, anterior_sw, track_len_sec,
        input  seg1_export, seg2_export, min_export, track_idx, track_end,
               elapsed_sec, dbg_state
    );

    modport slave (
        input  pausa_sw, siguiente_sw, anterior_sw, track_len_sec,
        output seg1_export, seg2_export, min_export, track_idx, track_end,
               elapsed_sec, dbg_state
    );
endinterface

// File: rtl/playtime_display.sv
// playtime_display: elapsed mm:ss playback timer and track index for the audio
// player, driving seconds/minutes seven-segment digits.
// Optional feature: define PLAYTIME_DEBOUNCE_EN to put a DEB_CYCLES debouncer
// behind each synchronised switch input.
module playtime_display #(
    parameter int CLK_HZ         = 50000000,
    parameter int MIN_DIGITS     = 2,
    parameter int NUM_TRACKS     = 8,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter int DEB_CYCLES     = 500000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    playtime_display_if.slave bus
);
    localparam int              PW       = $clog2(CLK_HZ);
    localparam int              TW       = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;
    localparam int              MW       = 4 * MIN_DIGITS;
    localparam logic [6:0]      SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [6:0]      SEG_ZERO = 7'h3F ^ SEG_INV;
    localparam logic [PW-1:0]   PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [TW-1:0]   TRK_LAST = TW'(NUM_TRACKS - 1);
    localparam logic [MW-1:0]   MIN_MAX  = {MIN_DIGITS{4'h9}};

    typedef enum logic {ST_RUN = 1'b0, ST_PAUSED = 1'b1} state_t;

    // Digit pattern (bits g..a), polarity applied at the end.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] v;
        case (d)
            4'd0:    v = 7'h3F;
            4'd1:    v = 7'h06;
            4'd2:    v = 7'h5B;
            4'd3:    v = 7'h4F;
            4'd4:    v = 7'h66;
            4'd5:    v = 7'h6D;
            4'd6:    v = 7'h7D;
            4'd7:    v = 7'h07;
            4'd8:    v = 7'h7F;
            4'd9:    v = 7'h6F;
            default: v = 7'h00;
        endcase
        return v ^ SEG_INV;
    endfunction

    logic [2:0]             r_sync1;     // {anterior, siguiente, pausa}
    logic [1:0]             r_sync2;     // {anterior, siguiente}
    logic                   w_pause_lvl;
    logic                   w_sig_lvl;
    logic                   w_ant_lvl;
    logic                   r_sig_prev;
    logic                   r_ant_prev;
    logic                   w_sig_rise;
    logic                   w_ant_rise;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_count_en;

    logic [PW-1:0]          r_prescale;
    logic [3:0]             r_sec_u;
    logic [2:0]             r_sec_t;
    logic [MW-1:0]          r_min;
    logic [MW-1:0]          w_min_inc;
    logic [11:0]            r_elapsed;
    logic [TW-1:0]          r_track;
    logic [TW-1:0]          w_trk_inc;
    logic [TW-1:0]          w_trk_dec;
    logic                   r_track_end;
    logic                   w_tick;
    logic                   w_at_max;
    logic                   w_len_hit;
    logic                   w_auto;

    logic [6:0]             r_seg1;
    logic [6:0]             r_seg2;
    logic [7*MIN_DIGITS-1:0] r_min_seg;

    // Two-flop synchronisers. For pausa the FSM state register is the second stage.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {bus.anterior_sw, bus.siguiente_sw, bus.pausa_sw};
            r_sync2 <= r_sync1[2:1];
        end
    end

`ifdef PLAYTIME_DEBOUNCE_EN
    localparam int            DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          r_pau_s2;
    logic [2:0]    w_deb_in;
    logic [2:0]    r_deb_lvl;
    logic [DW-1:0] r_deb_cnt [3];

    // Second synchroniser stage for pausa, needed only ahead of its debouncer.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_pau_s2 <= 1'b0;
        else             r_pau_s2 <= r_sync1[0];
    end

    assign w_deb_in = {r_sync2, r_pau_s2};

    // Each level follows its input only after DEB_CYCLES consecutive differing cycles.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_deb_lvl <= '0;
            for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_deb_in[i] == r_deb_lvl[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_deb_lvl[i] <= w_deb_in[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign w_pause_lvl = r_deb_lvl[0];
    assign w_sig_lvl   = r_deb_lvl[1];
    assign w_ant_lvl   = r_deb_lvl[2];
`else
    logic w_unused_deb;

    assign w_pause_lvl  = r_sync1[0];
    assign w_sig_lvl    = r_sync2[0];
    assign w_ant_lvl    = r_sync2[1];
    // Debounce length has no meaning without the debouncers.
    assign w_unused_deb = (DEB_CYCLES > 0);
`endif

    // Previous levels for rising-edge detection on the track buttons.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sig_prev <= 1'b0;
            r_ant_prev <= 1'b0;
        end else begin
            r_sig_prev <= w_sig_lvl;
            r_ant_prev <= w_ant_lvl;
        end
    end

    assign w_sig_rise = w_sig_lvl & ~r_sig_prev;
    assign w_ant_rise = w_ant_lvl & ~r_ant_prev;

    // FSM state register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) r_state <= ST_RUN;
        else             r_state <= w_state_next;
    end

    // FSM next state: RUN/PAUSED simply track the pause level.
    always_comb begin
        w_state_next = r_state;
        if (w_pause_lvl) w_state_next = ST_PAUSED;
        else             w_state_next = ST_RUN;
    end

    // FSM output: prescaler and time only move in RUN.
    always_comb begin
        w_count_en = 1'b0;
        if (r_state == ST_RUN) w_count_en = 1'b1;
    end

    assign w_tick    = w_count_en && (r_prescale == PRE_LAST);
    assign w_at_max  = (r_sec_u == 4'd9) && (r_sec_t == 3'd5) && (r_min == MIN_MAX);
    assign w_len_hit = (bus.track_len_sec != 12'd0) &&
                       (({1'b0, r_elapsed} + 13'd1) == {1'b0, bus.track_len_sec});
    assign w_auto    = w_tick && !w_at_max && w_len_hit;
    assign w_trk_inc = (r_track == TRK_LAST) ? '0 : r_track + TW'(1);
    assign w_trk_dec = (r_track == '0) ? TRK_LAST : r_track - TW'(1);

    // BCD ripple increment of the minute digits.
    always_comb begin
        logic v_carry;
        w_min_inc = r_min;
        v_carry   = 1'b1;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (v_carry) begin
                if (r_min[4*i +: 4] == 4'd9) begin
                    w_min_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_min_inc[4*i +: 4] = r_min[4*i +: 4] + 4'd1;
                    v_carry = 1'b0;
                end
            end
        end
    end

    // Time, elapsed and track counters. Manual change > auto-advance > second advance.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_prescale  <= '0;
            r_sec_u     <= '0;
            r_sec_t     <= '0;
            r_min       <= '0;
            r_elapsed   <= '0;
            r_track     <= '0;
            r_track_end <= 1'b0;
        end else begin
            r_track_end <= 1'b0;
            if (w_sig_rise || w_ant_rise) begin
                r_track    <= w_sig_rise ? w_trk_inc : w_trk_dec;
                r_prescale <= '0;
                r_sec_u    <= '0;
                r_sec_t    <= '0;
                r_min      <= '0;
                r_elapsed  <= '0;
            end else begin
                if (w_count_en) begin
                    r_prescale <= (r_prescale == PRE_LAST) ? '0 : r_prescale + PW'(1);
                end
                if (w_auto) begin
                    r_track     <= w_trk_inc;
                    r_track_end <= 1'b1;
                    r_sec_u     <= '0;
                    r_sec_t     <= '0;
                    r_min       <= '0;
                    r_elapsed   <= '0;
                end else if (w_tick && !w_at_max) begin
                    // elapsed saturates at 12 bits for long minute ranges
                    if (r_elapsed != 12'hFFF) r_elapsed <= r_elapsed + 12'd1;
                    if (r_sec_u == 4'd9) begin
                        r_sec_u <= 4'd0;
                        if (r_sec_t == 3'd5) begin
                            r_sec_t <= 3'd0;
                            r_min   <= w_min_inc;
                        end else begin
                            r_sec_t <= r_sec_t + 3'd1;
                        end
                    end else begin
                        r_sec_u <= r_sec_u + 4'd1;
                    end
                end
            end
        end
    end

    // Registered segment encoders, one cycle behind the counters.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_seg1    <= SEG_ZERO;
            r_seg2    <= SEG_ZERO;
            r_min_seg <= {MIN_DIGITS{SEG_ZERO}};
        end else begin
            r_seg1 <= seg7(r_sec_u);
            r_seg2 <= seg7({1'b0, r_sec_t});
            for (int i = 0; i < MIN_DIGITS; i++) begin
                r_min_seg[7*i +: 7] <= seg7(r_min[4*i +: 4]);
            end
        end
    end

    assign bus.seg1_export = r_seg1;
    assign bus.seg2_export = r_seg2;
    assign bus.min_export  = r_min_seg;
    assign bus.track_idx   = r_track;
    assign bus.track_end   = r_track_end;
    assign bus.elapsed_sec = r_elapsed;
    assign bus.dbg_state   = r_state;
endmodule
